// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART transmitter: register map,
// STATUS bit layout, serialiser state encoding and reset divisor.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_LEVEL_LSB = 8;
  localparam int STAT_OVF       = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // 50 MHz / 115200 baud
  localparam int UART_DEFAULT_DIV = 434;

  function automatic logic [31:0] pack_status(
    input logic       overflow,
    input logic [7:0] level,
    input logic       busy,
    input logic       full,
    input logic       empty
  );
    logic [31:0] s;
    s                          = '0;
    s[STAT_OVF]                = overflow;
    s[STAT_LEVEL_LSB +: 8]     = level;
    s[STAT_BUSY]               = busy;
    s[STAT_FULL]               = full;
    s[STAT_EMPTY]              = empty;
    return s;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data always shows the head entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             wr_en;
  logic             rd_en;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign level   = level_reg;
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO: register decode,
// divisor and overflow registers, bit timer and serialiser FSM.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = UART_DEFAULT_DIV
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sel_i,
  input  logic [1:0]  addr_i,
  input  logic        we_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd_o,
  output logic        tx_empty_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic             wr_txdata;
  logic             wr_status;
  logic             wr_div;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rd_data;
  logic [LW-1:0]    fifo_level;
  logic [7:0]       level_byte;
  logic             busy;
  logic [DIV_W-1:0] div_wr_value;
  logic [31:0]      rd_value;
  logic             unused_data;

  logic [1:0]       state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] bit_div_reg;
  logic [DIV_W-1:0] timer_reg;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt_reg;
  logic             txd_reg;
  logic             overflow_reg;
  logic [31:0]      data_reg;

  assign wr_txdata    = sel_i && we_i && (addr_i == REG_TXDATA);
  assign wr_status    = sel_i && we_i && (addr_i == REG_STATUS);
  assign wr_div       = sel_i && we_i && (addr_i == REG_DIV);
  assign busy         = (state_reg != ST_IDLE);
  assign fifo_pop     = !busy && !fifo_empty;
  assign div_wr_value = (data_i[DIV_W-1:0] == '0) ? DIV_W'(1) : data_i[DIV_W-1:0];
  // Only the low byte of the level fits the STATUS field.
  assign level_byte   = 8'(fifo_level);
  assign unused_data  = ^data_i;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (wr_txdata),
    .push_data (data_i[7:0]),
    .pop       (fifo_pop),
    .rd_data   (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_reg      <= DIV_W'(DEFAULT_DIV);
      overflow_reg <= 1'b0;
    end else begin
      if (wr_div) begin
        div_reg <= div_wr_value;
      end
      if (wr_txdata && fifo_full && !fifo_pop) begin
        overflow_reg <= 1'b1;
      end else if (wr_status && data_i[STAT_OVF]) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_value = '0;
    case (addr_i)
      REG_STATUS: rd_value = pack_status(overflow_reg, level_byte, busy, fifo_full, fifo_empty);
      REG_DIV:    rd_value = 32'(div_reg);
      REG_TXDATA: rd_value = '0;
      REG_RSVD:   rd_value = '0;
      default:    rd_value = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_reg <= '0;
    end else if (sel_i) begin
      data_reg <= rd_value;
    end
  end

  // txd_reg is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state and each bit lasts bit_div cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      bit_div_reg <= DIV_W'(1);
      timer_reg   <= '0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      txd_reg     <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          txd_reg <= 1'b1;
          if (!fifo_empty) begin
            shift_reg   <= fifo_rd_data;
            bit_div_reg <= div_reg;
            timer_reg   <= div_reg - DIV_W'(1);
            state_reg   <= ST_START;
            txd_reg     <= 1'b0;
          end
        end
        ST_START: begin
          if (timer_reg == '0) begin
            state_reg   <= ST_DATA;
            bit_cnt_reg <= 3'd0;
            timer_reg   <= bit_div_reg - DIV_W'(1);
            txd_reg     <= shift_reg[0];
          end else begin
            timer_reg <= timer_reg - DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (timer_reg == '0) begin
            timer_reg <= bit_div_reg - DIV_W'(1);
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= ST_STOP;
              txd_reg   <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              shift_reg   <= shift_reg >> 1;
              txd_reg     <= shift_reg[1];
            end
          end else begin
            timer_reg <= timer_reg - DIV_W'(1);
          end
        end
        ST_STOP: begin
          if (timer_reg == '0) begin
            state_reg <= ST_IDLE;
            txd_reg   <= 1'b1;
          end else begin
            timer_reg <= timer_reg - DIV_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          txd_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign data_o     = data_reg;
  assign txd_o      = txd_reg;
  assign tx_empty_o = fifo_empty && !busy;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a queue-based line model checked every cycle,
// directed scenarios with literal expectations, and a randomized bus phase.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int DEPTH = 16;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic [1:0]  addr  = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        txd;
  logic        tx_empty;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .FIFO_DEPTH  (DEPTH),
    .DIV_W       (16),
    .DEFAULT_DIV (434)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sel_i      (sel),
    .addr_i     (addr),
    .we_i       (we),
    .data_i     (wdata),
    .data_o     (rdata),
    .txd_o      (txd),
    .tx_empty_o (tx_empty)
  );

  // Line model: a frame is 10*div cycles starting with position 0; the bit
  // on the line is position/div (0 = start, 1..8 = data LSB first, 9 = stop).
  logic [7:0]  mq[$];
  bit          m_busy = 1'b0;
  int          m_pos  = 0;
  int          m_fdiv = 1;
  int          m_div  = 434;
  bit          m_ovf  = 1'b0;
  logic [31:0] m_dout = 32'd0;
  logic [7:0]  m_byte = 8'd0;
  bit          m_pop  = 1'b0;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd1: return {15'd0, m_ovf, 8'(mq.size()), 5'd0, m_busy,
                    (mq.size() == DEPTH), (mq.size() == 0)};
      2'd2: return 32'(m_div);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_txd();
    int k;
    if (!m_busy) return 1'b1;
    k = m_pos / m_fdiv;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_busy = 1'b0;
        m_pos  = 0;
        m_div  = 434;
        m_ovf  = 1'b0;
        m_dout = 32'd0;
      end else begin
        if (sel) m_dout = model_read(addr);
        m_pop = !m_busy && (mq.size() > 0);
        if (m_busy) begin
          m_pos = m_pos + 1;
          if (m_pos == 10 * m_fdiv) m_busy = 1'b0;
        end
        if (m_pop) begin
          m_byte = mq.pop_front();
          m_fdiv = m_div;
          m_pos  = 0;
          m_busy = 1'b1;
        end
        if (sel && we) begin
          case (addr)
            2'd0: if (mq.size() < DEPTH) mq.push_back(wdata[7:0]); else m_ovf = 1'b1;
            2'd1: if (wdata[16]) m_ovf = 1'b0;
            2'd2: m_div = (wdata[15:0] == 16'd0) ? 1 : int'(wdata[15:0]);
            default: ;
          endcase
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic step();
    @(negedge clk);
    cyc++;
    check("txd", 32'(txd), 32'(exp_txd()));
    check("tx_empty", 32'(tx_empty), 32'((mq.size() == 0) && !m_busy));
    check("data_o", rdata, m_dout);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    sel = 1'b0; we = 1'b0;
    $display("wr addr=%0d data=%08h cyc=%0d", a, d, cyc);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    sel = 1'b1; we = 1'b0; addr = a;
    step();
    v = rdata;
    sel = 1'b0;
    $display("rd addr=%0d data=%08h cyc=%0d", a, v, cyc);
  endtask

  logic [31:0] rv;
  logic [9:0]  pat;
  int          n;
  int          r;

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    bus_read(2'd1, rv);  check("reset_status", rv, 32'h1);
    bus_read(2'd2, rv);  check("reset_div", rv, 32'd434);

    // Single byte at DIV=4: start bit two cycles after the write, 40-cycle frame.
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'hA5);
    check("t1_cycle1_idle", 32'(txd), 32'd1);
    step();
    pat = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      check("t1_frame_bit", 32'(txd), 32'(pat[b]));
      repeat (4) step();
    end
    check("t1_after_frame", 32'(txd), 32'd1);
    bus_read(2'd1, rv);  check("t1_status", rv, 32'h1);

    // Divisor change mid-frame only affects the following frame.
    bus_write(2'd0, 32'h11);
    bus_write(2'd0, 32'h22);
    check("t4_start_low", 32'(txd), 32'd0);
    n = 0;
    while (!tx_empty && n < 400) begin
      if (n == 10) begin sel = 1'b1; we = 1'b1; addr = 2'd2; wdata = 32'd8; end
      step();
      if (n == 10) begin sel = 1'b0; we = 1'b0; end
      n++;
    end
    check("t4_two_frame_len", 32'(n), 32'd121);

    // Register corner cases.
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, rv);  check("div_zero_is_one", rv, 32'd1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rv);  check("addr3_read", rv, 32'd0);
    bus_read(2'd0, rv);  check("txdata_read", rv, 32'd0);
    bus_read(2'd2, rv);  check("div_kept", rv, 32'd1);

    // Fill the FIFO behind a slow frame, overflow it, then push on the pop cycle.
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h3C);
    repeat (2) step();
    bus_write(2'd2, 32'd1);
    for (int i = 0; i < 16; i++) bus_write(2'd0, 32'h80 + 32'(i));
    bus_read(2'd1, rv);  check("full_status", rv, 32'h0000_1006);
    bus_write(2'd0, 32'hEE);
    bus_read(2'd1, rv);  check("overflow_status", rv, 32'h0001_1006);
    bus_write(2'd1, 32'h0001_0000);
    bus_read(2'd1, rv);  check("overflow_cleared", rv, 32'h0000_1006);
    n = 0;
    while (m_busy && n < 100) begin step(); n++; end
    check("wait_idle_bound", 32'(m_busy), 32'd0);
    bus_write(2'd0, 32'h77);
    bus_read(2'd1, rv);  check("push_on_pop", rv, 32'h0000_1006);
    n = 0;
    while ((mq.size() > 0 || m_busy) && n < 1000) begin step(); n++; end
    step();
    check("drain_empty", 32'(tx_empty), 32'd1);

    // Randomized bus traffic.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      bus_write(2'd0, 32'($urandom_range(0, 255)));
      else if (r < 18) bus_read(2'($urandom_range(0, 3)), rv);
      else if (r < 20) bus_write(2'd2, 32'($urandom_range(0, 3)));
      else if (r < 22) bus_write(2'd1, $urandom);
      else if (r < 23) bus_write(2'd3, $urandom);
      else             step();
    end
    n = 0;
    while ((mq.size() > 0 || m_busy) && n < 2000) begin step(); n++; end
    check("random_drain_bound", 32'(m_busy), 32'd0);

    // Asynchronous reset in the middle of the data bits.
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h5A);
    bus_write(2'd0, 32'hC3);
    repeat (12) step();
    check("pre_reset_busy", 32'(m_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_txd", 32'(txd), 32'd1);
    check("async_rst_empty", 32'(tx_empty), 32'd1);
    check("async_rst_data", rdata, 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (60) step();
    bus_read(2'd1, rv);  check("post_rst_status", rv, 32'h1);
    bus_read(2'd2, rv);  check("post_rst_div", rv, 32'd434);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
